// File: rtl/uart_rx_if.sv
// Receive-side bus between uart_rx_sampler and the RX FIFO / STAT register.
// The rx_parity_err line exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic                    rx_valid;
    logic [PAYLOAD_BITS-1:0] rx_data;
    logic                    rx_frame_err;
    logic                    rx_overrun;
    logic                    rx_break;
    logic                    rx_full;
`ifdef UART_RX_PARITY_EN
    logic                    rx_parity_err;

    modport master (
        output rx_valid, rx_data, rx_frame_err, rx_overrun, rx_break, rx_parity_err,
        input  rx_full
    );
    modport slave (
        input  rx_valid, rx_data, rx_frame_err, rx_overrun, rx_break, rx_parity_err,
        output rx_full
    );
`else
    modport master (
        output rx_valid, rx_data, rx_frame_err, rx_overrun, rx_break,
        input  rx_full
    );
    modport slave (
        input  rx_valid, rx_data, rx_frame_err, rx_overrun, rx_break,
        output rx_full
    );
`endif
endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver front end with 3-sample mid-bit majority vote.
// Optional parity bit, state and rx_parity_err output: define UART_RX_PARITY_EN.
module uart_rx_sampler #(
    parameter int BIT_RATE     = 256_000,
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1,
`ifdef UART_RX_PARITY_EN
    parameter int PARITY_ODD   = 0,
`endif
    parameter int OVERSAMPLE   = 16
) (
    input  logic       g_clk,
    input  logic       g_reset,
    output logic       g_clk_req,
    input  logic       uart_rxd,
    input  logic       rx_en,
    uart_rx_if.master  rx_if
);

    localparam int TICK_CYCLES = CLK_HZ / (BIT_RATE * OVERSAMPLE);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(PAYLOAD_BITS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SAMP_V0   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_V1   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMP_V2   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(PAYLOAD_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY   = 3'd3,
`endif
        S_STOP     = 3'd4,
        S_BRK_WAIT = 3'd5
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

`ifdef UART_RX_PARITY_EN
    function automatic logic parity_mismatch(input logic [PAYLOAD_BITS-1:0] d,
                                             input logic                    p);
        return (^{d, p}) != 1'(PARITY_ODD);
    endfunction
`endif

    state_t                  state_q, state_d;
    logic                    sync0_q, sync0_d;
    logic                    sync1_q, sync1_d;
    logic                    rxs_prev_q, rxs_prev_d;
    logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]           sample_cnt_q, sample_cnt_d;
    logic [1:0]              samp_q, samp_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                    stop_cnt_q, stop_cnt_d;
    logic                    stop_err_q, stop_err_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [PAYLOAD_BITS-1:0] rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    rx_frame_err_q, rx_frame_err_d;
    logic                    rx_overrun_q, rx_overrun_d;
    logic                    rx_break_q, rx_break_d;
    logic                    g_clk_req_q, g_clk_req_d;
`ifdef UART_RX_PARITY_EN
    logic                    par_q, par_d;
    logic                    rx_parity_err_q, rx_parity_err_d;
`endif

    logic rxs_s;
    logic tick_s;
    logic bit_end_s;
    logic vote_evt_s;
    logic vote_s;
    logic stop_err_now_s;
    logic is_break_s;

    assign rxs_s = sync1_q;

    // Sample timing, vote and receive state machine.
    always_comb begin
        state_d         = state_q;
        sync0_d         = uart_rxd;
        sync1_d         = sync0_q;
        rxs_prev_d      = sync1_q;
        tick_cnt_d      = tick_cnt_q;
        sample_cnt_d    = sample_cnt_q;
        samp_d          = samp_q;
        bit_cnt_d       = bit_cnt_q;
        stop_cnt_d      = stop_cnt_q;
        stop_err_d      = stop_err_q;
        shift_d         = shift_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = 1'b0;
        rx_frame_err_d  = rx_frame_err_q;
        rx_overrun_d    = rx_overrun_q;
        rx_break_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d           = par_q;
        rx_parity_err_d = rx_parity_err_q;
`endif

        tick_s         = (tick_cnt_q == TICK_LAST);
        bit_end_s      = tick_s && (sample_cnt_q == SAMP_LAST);
        vote_evt_s     = tick_s && (sample_cnt_q == SAMP_V2);
        vote_s         = maj3(samp_q[0], samp_q[1], rxs_s);
        stop_err_now_s = stop_err_q | ~vote_s;
`ifdef UART_RX_PARITY_EN
        is_break_s     = (shift_q == '0) && stop_err_now_s && !par_q;
`else
        is_break_s     = (shift_q == '0) && stop_err_now_s;
`endif

        if (state_q != S_IDLE) begin
            if (tick_s) begin
                tick_cnt_d   = '0;
                sample_cnt_d = (sample_cnt_q == SAMP_LAST) ? '0 : sample_cnt_q + SW'(1);
                if (sample_cnt_q == SAMP_V0) begin
                    samp_d[0] = rxs_s;
                end else if (sample_cnt_q == SAMP_V1) begin
                    samp_d[1] = rxs_s;
                end else begin
                    samp_d = samp_q;
                end
            end else begin
                tick_cnt_d = tick_cnt_q + TW'(1);
            end
        end else begin
            tick_cnt_d   = '0;
            sample_cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                stop_err_d = 1'b0;
                if (rxs_prev_q && !rxs_s && rx_en) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                // A start bit that votes high was line noise; drop it silently.
                if (vote_evt_s && vote_s) begin
                    state_d = S_IDLE;
                end else if (bit_end_s) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (vote_evt_s) begin
                    shift_d = {vote_s, shift_q[PAYLOAD_BITS-1:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (bit_end_s) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (vote_evt_s) begin
                    par_d = vote_s;
                end else begin
                    par_d = par_q;
                end
                if (bit_end_s) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                // Decide at the last stop vote, not at bit end, so a new start edge is not missed.
                if (vote_evt_s && (stop_cnt_q == STOP_LAST)) begin
                    if (is_break_s) begin
                        rx_break_d = 1'b1;
                        state_d    = S_BRK_WAIT;
                    end else begin
                        rx_valid_d      = 1'b1;
                        rx_data_d       = shift_q;
                        rx_frame_err_d  = stop_err_now_s;
                        rx_overrun_d    = rx_if.rx_full;
`ifdef UART_RX_PARITY_EN
                        rx_parity_err_d = parity_mismatch(shift_q, par_q);
`endif
                        state_d         = S_IDLE;
                    end
                end else if (vote_evt_s) begin
                    stop_err_d = stop_err_now_s;
                end else if (bit_end_s) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BRK_WAIT: begin
                if (rxs_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BRK_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered form of (state != IDLE) | (sync0 != rxs), evaluated on next-state values.
        g_clk_req_d = (state_d != S_IDLE) | (sync0_d != sync1_d);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q         <= S_IDLE;
            sync0_q         <= 1'b1;
            sync1_q         <= 1'b1;
            rxs_prev_q      <= 1'b1;
            tick_cnt_q      <= '0;
            sample_cnt_q    <= '0;
            samp_q          <= 2'b00;
            bit_cnt_q       <= '0;
            stop_cnt_q      <= 1'b0;
            stop_err_q      <= 1'b0;
            shift_q         <= '0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_frame_err_q  <= 1'b0;
            rx_overrun_q    <= 1'b0;
            rx_break_q      <= 1'b0;
            g_clk_req_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q           <= 1'b0;
            rx_parity_err_q <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            sync0_q         <= sync0_d;
            sync1_q         <= sync1_d;
            rxs_prev_q      <= rxs_prev_d;
            tick_cnt_q      <= tick_cnt_d;
            sample_cnt_q    <= sample_cnt_d;
            samp_q          <= samp_d;
            bit_cnt_q       <= bit_cnt_d;
            stop_cnt_q      <= stop_cnt_d;
            stop_err_q      <= stop_err_d;
            shift_q         <= shift_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            rx_frame_err_q  <= rx_frame_err_d;
            rx_overrun_q    <= rx_overrun_d;
            rx_break_q      <= rx_break_d;
            g_clk_req_q     <= g_clk_req_d;
`ifdef UART_RX_PARITY_EN
            par_q           <= par_d;
            rx_parity_err_q <= rx_parity_err_d;
`endif
        end
    end

    assign g_clk_req          = g_clk_req_q;
    assign rx_if.rx_valid     = rx_valid_q;
    assign rx_if.rx_data      = rx_data_q;
    assign rx_if.rx_frame_err = rx_frame_err_q;
    assign rx_if.rx_overrun   = rx_overrun_q;
    assign rx_if.rx_break     = rx_break_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.rx_parity_err = rx_parity_err_q;
`endif

endmodule
